// File: rtl/alu_result_stage.sv
// ALU result stage: captures the 64-bit Z result and keeps the ZLO/ZHI and HI/LO registers.
// Derives the zero/negative flags and streams the result onto the 32-bit bus over valid/ready.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_EMPTY   | nothing to send; a new result can always be captured
// S_HOLD_LO | presenting zlo; if pending_hi is set, zhi is sent after it
// S_HOLD_HI | presenting zhi, the second word of a mul/div result
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                  Clk,
    input  logic                  Clear_n,
    input  logic [2*DATA_W-1:0]   z_in,
    input  logic [OP_W-1:0]       z_op,
    input  logic                  z_inc_pc,
    input  logic                  z_valid,
    output logic                  z_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_is_hi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     zlo,
    output logic [DATA_W-1:0]     zhi,
    output logic [DATA_W-1:0]     hi_reg,
    output logic [DATA_W-1:0]     lo_reg,
    output logic                  flag_zero,
    output logic                  flag_neg,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_HOLD_LO = 2'd1,
        S_HOLD_HI = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   pending_hi;
    logic   capture;
    logic   two_word;

    // Multiply and divide produce a two-word result unless it is a PC increment.
    assign two_word = (z_op <= OP_W'(1)) && !z_inc_pc;

    always_comb begin
        z_ready = 1'b0;
        unique case (state)
            S_EMPTY:   z_ready = 1'b1;
            S_HOLD_LO: z_ready = !pending_hi && out_ready;
            S_HOLD_HI: z_ready = out_ready;
            default:   z_ready = 1'b0;
        endcase
    end

    assign capture = z_valid && z_ready;

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_EMPTY: begin
                if (capture) state_next = S_HOLD_LO;
            end
            S_HOLD_LO: begin
                if (out_ready) begin
                    if (pending_hi)   state_next = S_HOLD_HI;
                    else if (capture) state_next = S_HOLD_LO;
                    else              state_next = S_EMPTY;
                end
            end
            S_HOLD_HI: begin
                if (out_ready) state_next = capture ? S_HOLD_LO : S_EMPTY;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_is_hi = 1'b0;
        out_data  = '0;
        unique case (state)
            S_HOLD_LO: begin
                out_valid = 1'b1;
                out_data  = zlo;
            end
            S_HOLD_HI: begin
                out_valid = 1'b1;
                out_is_hi = 1'b1;
                out_data  = zhi;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            zlo        <= '0;
            zhi        <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            flag_zero  <= 1'b0;
            flag_neg   <= 1'b0;
            pending_hi <= 1'b0;
        end else if (capture) begin
            zlo        <= z_in[DATA_W-1:0];
            zhi        <= z_in[2*DATA_W-1:DATA_W];
            pending_hi <= two_word;
            if (two_word) begin
                lo_reg    <= z_in[DATA_W-1:0];
                hi_reg    <= z_in[2*DATA_W-1:DATA_W];
                flag_zero <= (z_in == '0);
                flag_neg  <= z_in[2*DATA_W-1];
            end else begin
                flag_zero <= (z_in[DATA_W-1:0] == '0);
                flag_neg  <= z_in[DATA_W-1];
            end
        end
    end

    // A dropped capture on the same edge as a clear leaves overrun set.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            overrun <= 1'b0;
        end else if (z_valid && !z_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream of the ALU. Captures the 64-bit Z result on a strobe and keeps the architectural ZLO/ZHI and HI/LO registers.
- Derives zero and negative flags.
- Streams the result onto the 32-bit internal bus over a valid/ready handshake.
- Multiply and divide (ops 0/1) emit two bus words, LO then HI. All other ops emit one word.

Parameters:
- DATA_W, 32, bus word width; Z width is 2*DATA_W.
- OP_W, 4, width of the ALU control code.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Clear_n  in  1  asynchronous active-low reset.
- z_in  in  64  ALU Z output; stable at posedge while z_valid=1.
- z_op  in  4  ALU control code that produced z_in.
- z_inc_pc  in  1  result is a PC increment; forces single-word handling.
- z_valid  in  1  capture request, one cycle per result.
- z_ready  out  1  stage can accept z_valid this cycle.
- out_data  out  32  bus word.
- out_is_hi  out  1  out_data is the upper half of a two-word result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  bus consumer accepts the word.
- zlo  out  32  last captured z_in[31:0].
- zhi  out  32  last captured z_in[63:32].
- hi_reg  out  32  z_in[63:32] of last mul/div (remainder or product high).
- lo_reg  out  32  z_in[31:0] of last mul/div (quotient or product low).
- flag_zero  out  1  zero flag of last capture.
- flag_neg  out  1  negative flag of last capture.
- overrun  out  1  sticky; z_valid arrived while z_ready=0.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (Clear_n=0, asynchronous):
  - All registers are 0: zlo, zhi, hi_reg, lo_reg, flags, overrun, out_is_hi.
  - State EMPTY: out_valid=0, out_data=0.
  - Release is sampled at the next posedge.
  - A reset mid-transfer discards pending words.
- Word count:
  - two_word = (z_op==0 || z_op==1) && !z_inc_pc.
  - Op codes 2..15 are single word, including the undefined codes 12..15.
- States:
  - EMPTY: out_valid=0.
  - HOLD_LO: out_valid=1, out_data=zlo, out_is_hi=0.
  - HOLD_HI: out_valid=1, out_data=zhi, out_is_hi=1.
- z_ready (combinational) is 1 when any of these holds:
  - state==EMPTY;
  - state==HOLD_LO && !pending_hi && out_ready;
  - state==HOLD_HI && out_ready.
- Capture (z_valid && z_ready at posedge):
  - zlo <= z_in[31:0]; zhi <= z_in[63:32].
  - If two_word: hi_reg/lo_reg load as well and pending_hi <= 1. Otherwise pending_hi <= 0.
  - Flags for two_word: flag_zero = (z_in==0), flag_neg = z_in[63].
  - Flags otherwise: flag_zero = (z_in[31:0]==0), flag_neg = z_in[31].
  - Next state is HOLD_LO.
- Latency: out_valid rises exactly one cycle after capture. A back-to-back capture on the same edge as the last-word handshake keeps out_valid high with no bubble.
- Transitions:
  - HOLD_LO with out_ready: if pending_hi, go to HOLD_HI. Otherwise go to HOLD_LO (if a capture happens on the same edge) or EMPTY.
  - HOLD_HI with out_ready: go to HOLD_LO on a same-edge capture, else EMPTY.
  - Without out_ready, state and data hold.
- Stability: out_data, out_is_hi and out_valid stay stable while out_valid && !out_ready.
- Dropped capture: z_valid with z_ready=0 is ignored, with no register change, and sets overrun on that edge.
- overrun priority: a set on the same edge as clr_overrun wins.
- zlo/zhi/flags change only on capture. hi_reg/lo_reg change only on a two_word capture.
- No combinational path from z_in to any output.

Test Plan:
- Reset then add: Clear_n pulse; z_op=2, z_in=0x0000_0000_0000_0007, z_valid one cycle, out_ready=1.
  - Next cycle: out_valid=1, out_data=7, out_is_hi=0, flag_zero=0, flag_neg=0.
  - Following cycle: EMPTY, and hi_reg/lo_reg are still 0.
- Multiply: z_op=1, z_in=0xFFFF_FFFF_0000_0002, out_ready=1.
  - Bus sees 0x0000_0002 (out_is_hi=0) then 0xFFFF_FFFF (out_is_hi=1) on consecutive cycles.
  - hi_reg=0xFFFF_FFFF, lo_reg=2, flag_neg=1.
- Backpressure: out_ready=0 for 3 cycles after a divide capture of 0x0000_0003_0000_0005.
  - out_data holds 5 and z_ready=0.
  - A z_valid in that window sets overrun=1 and leaves zlo=5.
  - Releasing out_ready delivers 5 then 3.
- Back-to-back: sub result 0xFFFF_FFFF (z_op=3) accepted, with a new z_valid (z_op=8, z_in=0x10) on the same edge and out_ready=1.
  - No out_valid gap; second word is 0x10.
  - flag_neg toggles 1→0.
- inc_pc override: z_op=0, z_inc_pc=1, z_in=0x0000_0000_0000_0101.
  - Single word 0x101; hi_reg/lo_reg unchanged.
- Async reset mid-HOLD_HI (Clear_n low between edges): out_valid drops immediately, all outputs read 0. After release, clr_overrun and set behave per the priority rule.
